run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and breakpoint width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the step-count and cycle-counter width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  core clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted on an edge where cmd_valid && cmd_ready.
REQ-008 cmd_op  input  2  00 STEP, 01 RUN_N, 10 RUN_BP, 11 HALT.
REQ-009 cmd_count  input  CNT_W  cycle count for RUN_N; ignored for other ops.
REQ-010 bp_en  input  1  breakpoint compare enable.
REQ-011 bp_addr  input  XLEN  breakpoint PC.
REQ-012 pc_addr  input  XLEN  current core PC (the core's pc_addr).
REQ-013 cnt_clr  input  1  synchronous clear of cycles.
REQ-014 core_en  output  1  core advances on an edge where core_en=1.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 done_cause  output  2  00 count exhausted, 01 breakpoint, 10 halt; valid while done=1.
REQ-018 cycles  output  CNT_W  count of enabled core cycles.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE.
REQ-020 Transitions SHALL be: IDLE->RUN on acceptance of STEP/RUN_N/RUN_BP; IDLE->DONE on HALT acceptance (cause 10, zero core_en cycles); RUN->DONE on the edge where stop=1; DONE->IDLE unconditionally.
REQ-021 cmd_ready SHALL be 1 in IDLE, 1 in RUN only when cmd_op=11, and 0 in DONE; non-HALT commands during RUN SHALL stall (not be dropped).
REQ-022 On acceptance, remaining SHALL load 1 for STEP, cmd_count for RUN_N, and don't-care for RUN_BP; the first flag SHALL be set.
REQ-023 In RUN, stop SHALL be high when any of: a HALT is accepted this cycle; mode RUN_BP && bp_en && pc_addr==bp_addr && !first; mode STEP/RUN_N && remaining==0.
REQ-024 Cause priority SHALL be halt > breakpoint > count, latched on the RUN->DONE edge.
REQ-025 core_en SHALL be combinational: (state==RUN) && !stop; it SHALL never be high in IDLE or DONE.
REQ-026 Each edge with core_en=1 SHALL decrement remaining by 1 (modes STEP/RUN_N) and clear first.
REQ-027 first SHALL suppress the breakpoint compare for the first enabled cycle, so a RUN_BP issued while sitting on bp_addr advances.
REQ-028 RUN_N with cmd_count=0 SHALL enter RUN, give zero core_en cycles, and finish with cause 00.
REQ-029 Timing, with C0 the cycle after the accept edge: STEP SHALL give core_en=1 in C0 only, core_en=0 in C1, and done=1 in C2; RUN_N n SHALL give core_en in C0..C(n-1) and done in C(n+1).
REQ-030 done SHALL be high exactly for the one cycle in DONE.
REQ-031 cycles SHALL increment on each edge with core_en=1 and saturate at 2^CNT_W-1; cnt_clr SHALL win over increment (result 0).
REQ-032 RUN_BP with bp_en=0 SHALL run indefinitely until HALT.

Reset
REQ-033 Assertion of rst=0 SHALL asynchronously force state=IDLE, core_en=0, busy=0, done=0, done_cause=00, cycles=0, remaining=0 and first=0, and cmd_ready SHALL read 1 after deassertion.
REQ-034 Reset mid-RUN SHALL abort with no done pulse; the first post-reset edge with cmd_valid SHALL be accepted normally.

Verification
REQ-035 STEP from IDLE -> exactly one core_en cycle in C0; done in C2 with cause 00; cycles=1.
REQ-036 RUN_N count=5 -> core_en in C0..C4; done in C6 with cause 00; cycles=5. Repeat with count=0 -> no core_en; done in C1 with cause 00.
REQ-037 RUN_BP with bp_addr=0x10, pc_addr reaching 0x10 after 3 enabled cycles -> core_en=0 in the cycle where pc_addr==0x10; done with cause 01; reissuing RUN_BP at pc 0x10 advances at least one cycle.
REQ-038 RUN_N 100, HALT at C10 -> core_en=0 in C10; done in C11 with cause 10; cycles=10. A STEP presented during RUN -> cmd_ready=0 until IDLE.
REQ-039 RUN_N 50, rst=0 at C20 -> core_en drops immediately; no done pulse; all outputs reset; a STEP after release behaves per REQ-035.
REQ-040 cycles preloaded near max with CNT_W=4 -> saturates at 15; cnt_clr together with core_en -> 0.

Source files
------------

// File: rtl/run_controller_if.sv
// Command channel of the run controller: a valid/ready handshake carrying an
// opcode and a cycle count.
interface run_controller_if #(
    parameter int unsigned CNT_W = 32
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );

endinterface

// File: rtl/run_controller.sv
// Run controller: gates the core clock-enable for single steps, counted runs
// and breakpoint runs, and reports completion with a one-cycle done pulse.
module run_controller #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    run_controller_if.slave  cmd,
    input  logic             bp_en,
    input  logic [XLEN-1:0]  bp_addr,
    input  logic [XLEN-1:0]  pc_addr,
    input  logic             cnt_clr,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OpStep  = 2'b00,
        OpRunN  = 2'b01,
        OpRunBp = 2'b10,
        OpHalt  = 2'b11
    } op_e;

    localparam logic [1:0]       CauseCount = 2'b00;
    localparam logic [1:0]       CauseBp    = 2'b01;
    localparam logic [1:0]       CauseHalt  = 2'b10;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic accept;
    logic counted;
    logic halt_acc;
    logic bp_hit;
    logic cnt_end;
    logic stop;

    // Stop conditions evaluated against the current RUN context.
    always_comb begin
        accept   = cmd.cmd_valid && cmd.cmd_ready;
        counted  = (mode_q == OpStep) || (mode_q == OpRunN);
        halt_acc = (state_q == StRun) && cmd.cmd_valid && (cmd.cmd_op == OpHalt);
        // first masks the compare so a run issued while parked on bp_addr still advances.
        bp_hit   = (mode_q == OpRunBp) && bp_en && (pc_addr == bp_addr) && !first_q;
        cnt_end  = counted && (remaining_q == '0);
        stop     = (state_q == StRun) && (halt_acc || bp_hit || cnt_end);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (cmd.cmd_op == OpHalt) ? StDone : StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; only HALT may pass while running, others stall.
    always_comb begin
        cmd.cmd_ready = 1'b0;
        core_en       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            StIdle: cmd.cmd_ready = 1'b1;
            StRun: begin
                cmd.cmd_ready = (cmd.cmd_op == OpHalt);
                core_en       = !stop;
                busy          = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign done_cause = cause_q;
    assign cycles     = cycles_q;

    // Run context, completion cause and enabled-cycle counter next-state.
    always_comb begin
        mode_d      = mode_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        cause_d     = cause_q;
        cycles_d    = cycles_q;

        if ((state_q == StIdle) && accept) begin
            mode_d  = cmd.cmd_op;
            first_d = 1'b1;
            case (cmd.cmd_op)
                OpStep:  remaining_d = CntOne;
                OpRunN:  remaining_d = cmd.cmd_count;
                default: remaining_d = '0;
            endcase
            if (cmd.cmd_op == OpHalt) begin
                cause_d = CauseHalt;
            end
        end

        if (core_en) begin
            first_d = 1'b0;
            if (counted) begin
                remaining_d = remaining_q - CntOne;
            end
        end

        // Priority: halt over breakpoint over count exhaustion.
        if (stop) begin
            cause_d = halt_acc ? CauseHalt : (bp_hit ? CauseBp : CauseCount);
        end

        if (cnt_clr) begin
            cycles_d = '0;
        end else if (core_en && (cycles_q != '1)) begin
            cycles_d = cycles_q + CntOne;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= 2'b00;
            remaining_q <= '0;
            first_q     <= 1'b0;
            cause_q     <= CauseCount;
            cycles_q    <= '0;
        end else begin
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            cause_q     <= cause_d;
            cycles_q    <= cycles_d;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a scoreboard of expected done cause/cycle count is
// filled as commands are issued and drained on every done pulse; cycle-exact
// core_en/ready checks are made inline. A second instance with CNT_W=4
// exercises counter saturation and clear priority.
module tb_run_controller;

    localparam logic [1:0] OpStep  = 2'b00;
    localparam logic [1:0] OpRunN  = 2'b01;
    localparam logic [1:0] OpRunBp = 2'b10;
    localparam logic [1:0] OpHalt  = 2'b11;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_addr;
    logic        cnt_clr;
    logic        core_en;
    logic        busy;
    logic        done;
    logic [1:0]  done_cause;
    logic [31:0] cycles;

    logic        pc_set;
    logic [31:0] pc_init;

    logic        cnt_clr4;
    logic        core_en4;
    logic        busy4;
    logic        done4;
    logic [1:0]  done_cause4;
    logic [3:0]  cycles4;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];
    exp_t sb_e;

    run_controller_if #(.CNT_W(32)) ifc ();
    run_controller_if #(.CNT_W(4))  ifc4 ();

    run_controller #(.XLEN(32), .CNT_W(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc_addr    (pc_addr),
        .cnt_clr    (cnt_clr),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .done_cause (done_cause),
        .cycles     (cycles)
    );

    run_controller #(.XLEN(32), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .cmd        (ifc4),
        .bp_en      (1'b0),
        .bp_addr    (32'h0),
        .pc_addr    (32'h0),
        .cnt_clr    (cnt_clr4),
        .core_en    (core_en4),
        .busy       (busy4),
        .done       (done4),
        .done_cause (done_cause4),
        .cycles     (cycles4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Minimal core model: PC advances by 4 on every enabled edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_addr <= 32'h0;
        end else if (pc_set) begin
            pc_addr <= pc_init;
        end else if (core_en) begin
            pc_addr <= pc_addr + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard drain on every done pulse.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_cause", 64'(done_cause), 64'(sb_e.cause));
                check("sb_cycles", 64'(cycles), 64'(sb_e.cyc));
            end
        end
    end

    task automatic push_exp(input logic [1:0] cause, input logic [31:0] cyc);
        exp_t e;
        e.cause = cause;
        e.cyc   = cyc;
        sb_q.push_back(e);
    endtask

    // Present a command and hold it until accepted; returns just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] count);
        int w;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_count = count;
        #1;
        w = 0;
        while (!ifc.cmd_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("issue_ready", 64'(ifc.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic clear_cycles();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        @(negedge clk);
        pc_set  = 1'b1;
        pc_init = v;
        @(negedge clk);
        pc_set  = 1'b0;
    endtask

    task automatic run_step(input string tag);
        push_exp(2'b00, 32'd1);
        issue(OpStep, 32'd0);
        @(negedge clk);
        check({tag, "_c0_en"}, 64'(core_en), 64'd1);
        check({tag, "_c0_busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, "_c1_en"}, 64'(core_en), 64'd0);
        @(negedge clk);
        check({tag, "_c2_done"}, 64'(done), 64'd1);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(ifc.cmd_ready), 64'd1);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
    endtask

    task automatic issue4(input logic [1:0] op, input logic [3:0] count);
        @(negedge clk);
        ifc4.cmd_valid = 1'b1;
        ifc4.cmd_op    = op;
        ifc4.cmd_count = count;
        #1;
        check("w4_ready", 64'(ifc4.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        ifc4.cmd_valid = 1'b0;
    endtask

    task automatic wait_done4(input string tag, input logic [3:0] exp_cyc);
        int w;
        w = 0;
        while (!done4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_done"}, 64'(done4), 64'd1);
        check({tag, "_cause"}, 64'(done_cause4), 64'd0);
        check({tag, "_cycles"}, 64'(cycles4), 64'(exp_cyc));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bp_en          = 1'b0;
        bp_addr        = 32'h0;
        cnt_clr        = 1'b0;
        pc_set         = 1'b0;
        pc_init        = 32'h0;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_op     = OpStep;
        ifc.cmd_count  = 32'h0;
        ifc4.cmd_valid = 1'b0;
        ifc4.cmd_op    = OpStep;
        ifc4.cmd_count = 4'h0;
        cnt_clr4       = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_core_en", 64'(core_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cause", 64'(done_cause), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_ready", 64'(ifc.cmd_ready), 64'd1);

        // Single step.
        run_step("step");

        // RUN_N 5: enabled C0..C4, done C6.
        clear_cycles();
        push_exp(2'b00, 32'd5);
        issue(OpRunN, 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("runn5_en", 64'(core_en), 64'd1);
        end
        @(negedge clk);
        check("runn5_c5_en", 64'(core_en), 64'd0);
        @(negedge clk);
        check("runn5_c6_done", 64'(done), 64'd1);

        // RUN_N 0: no enabled cycle, done C1.
        clear_cycles();
        push_exp(2'b00, 32'd0);
        issue(OpRunN, 32'd0);
        @(negedge clk);
        check("runn0_c0_en", 64'(core_en), 64'd0);
        check("runn0_c0_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("runn0_c1_done", 64'(done), 64'd1);

        // HALT from IDLE: straight to DONE with halt cause.
        clear_cycles();
        push_exp(2'b10, 32'd0);
        issue(OpHalt, 32'd0);
        @(negedge clk);
        check("halt_idle_done", 64'(done), 64'd1);
        check("halt_idle_en", 64'(core_en), 64'd0);

        // RUN_BP: pc 4 -> 0x10 after three enabled cycles.
        set_pc(32'h4);
        bp_addr = 32'h10;
        bp_en   = 1'b1;
        clear_cycles();
        push_exp(2'b01, 32'd3);
        issue(OpRunBp, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_run_en", 64'(core_en), 64'd1);
        end
        @(negedge clk);
        check("bp_hit_pc", 64'(pc_addr), 64'h10);
        check("bp_hit_en", 64'(core_en), 64'd0);
        @(negedge clk);
        check("bp_done", 64'(done), 64'd1);

        // Reissue while parked on the breakpoint: must advance, then HALT.
        clear_cycles();
        push_exp(2'b10, 32'd2);
        issue(OpRunBp, 32'd0);
        @(negedge clk);
        check("bp_reissue_c0_en", 64'(core_en), 64'd1);
        @(negedge clk);
        check("bp_reissue_pc", 64'(pc_addr), 64'h14);
        check("bp_reissue_c1_en", 64'(core_en), 64'd1);
        issue(OpHalt, 32'd0);
        @(negedge clk);
        check("bp_reissue_done", 64'(done), 64'd1);

        // RUN_BP with bp_en=0 keeps running across bp_addr until HALT.
        bp_en = 1'b0;
        set_pc(32'h8);
        clear_cycles();
        push_exp(2'b10, 32'd8);
        issue(OpRunBp, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bpoff_en", 64'(core_en), 64'd1);
        end
        issue(OpHalt, 32'd0);
        @(negedge clk);
        check("bpoff_done", 64'(done), 64'd1);

        // RUN_N 100 with a stalled STEP, HALT in C10, then the STEP is taken.
        clear_cycles();
        push_exp(2'b10, 32'd10);
        push_exp(2'b00, 32'd11);
        issue(OpRunN, 32'd100);
        @(negedge clk);
        check("halt_c0_en", 64'(core_en), 64'd1);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            ifc.cmd_valid = 1'b1;
            ifc.cmd_op    = OpStep;
            #1;
            check("stall_ready", 64'(ifc.cmd_ready), 64'd0);
        end
        @(negedge clk);
        ifc.cmd_op = OpHalt;
        #1;
        check("halt_c10_ready", 64'(ifc.cmd_ready), 64'd1);
        check("halt_c10_en", 64'(core_en), 64'd0);
        @(posedge clk);
        #1;
        ifc.cmd_op = OpStep;
        @(negedge clk);
        check("halt_c11_done", 64'(done), 64'd1);
        check("halt_c11_ready", 64'(ifc.cmd_ready), 64'd0);
        @(negedge clk);
        check("stall_idle_ready", 64'(ifc.cmd_ready), 64'd1);
        check("stall_idle_en", 64'(core_en), 64'd0);
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
        @(negedge clk);
        check("stall_step_en", 64'(core_en), 64'd1);
        @(negedge clk);
        check("stall_step_c1_en", 64'(core_en), 64'd0);
        @(negedge clk);
        check("stall_step_done", 64'(done), 64'd1);

        // Reset in the middle of RUN_N 50: abort with no done pulse.
        clear_cycles();
        issue(OpRunN, 32'd50);
        repeat (20) @(negedge clk);
        @(negedge clk);
        check("abort_c20_en", 64'(core_en), 64'd1);
        rst = 1'b0;
        #1;
        check("abort_en", 64'(core_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_cause", 64'(done_cause), 64'd0);
        check("abort_cycles", 64'(cycles), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 64'(ifc.cmd_ready), 64'd1);
        run_step("post_rst");

        // Narrow counter: reach max, saturate, then clear beats increment.
        issue4(OpRunN, 4'd15);
        wait_done4("sat_fill", 4'd15);
        issue4(OpRunN, 4'd3);
        wait_done4("sat_hold", 4'd15);
        issue4(OpRunN, 4'd5);
        @(negedge clk);
        @(negedge clk);
        check("clr_en", 64'(core_en4), 64'd1);
        check("clr_busy", 64'(busy4), 64'd1);
        cnt_clr4 = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr4 = 1'b0;
        check("clr_wins", 64'(cycles4), 64'd0);
        wait_done4("clr_after", 4'd3);

        @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
